// File: rtl/load_writeback_unit.sv
// Multi-cycle load engine: word read over req/gnt/rvalid, byte/half/word extension, one-cycle RF write.
// Optional WAIT-state abort counter is compiled in when LOAD_TIMEOUT_EN is defined.
module load_writeback_unit #(
    parameter int RF_ADDR_W      = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [31:0]          ld_addr,
    input  logic [RF_ADDR_W-1:0] ld_rd,
    input  logic [2:0]           ld_funct3,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [31:0]          mem_rdata,
    output logic [RF_ADDR_W-1:0] rf_rd,
    output logic [31:0]          rf_rd_din,
    output logic                 rf_write_enable,
    output logic                 busy,
    output logic                 misaligned_err,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            addr_q;
    logic [RF_ADDR_W-1:0]   rd_q;
    logic [2:0]             funct3_q;
    logic                   accept;
    logic                   bad_req;
    logic                   timeout_hit;
    logic                   misaligned_q;

    // Unknown funct3 or an access that straddles its natural alignment.
    function automatic logic is_bad(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return lane[0];
            3'd2:       return lane != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane[1], 4'b0000});
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return word;
        endcase
    endfunction

    assign accept  = ld_valid && (state == S_IDLE);
    assign bad_req = is_bad(ld_funct3, ld_addr[1:0]);

`ifdef LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state == S_REQ && mem_gnt)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_WAIT) && !mem_rvalid && (wait_cnt == WAIT_LAST);
    assign timeout_err = timeout_q;
`else
    logic [31:0] timeout_cfg_unused;
    assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept && !bad_req) state_next = S_REQ;
            S_REQ:  if (mem_gnt)            state_next = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid)
                    state_next = S_WB;
                else if (timeout_hit)
                    state_next = S_IDLE;
            end
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready        = 1'b0;
        mem_req         = 1'b0;
        rf_write_enable = 1'b0;
        busy            = 1'b1;
        case (state)
            S_IDLE: begin
                ld_ready = 1'b1;
                busy     = 1'b0;
            end
            S_REQ:   mem_req = 1'b1;
            S_WB:    rf_write_enable = (rd_q != '0);
            default: ;
        endcase
    end

    assign mem_addr       = {addr_q[31:2], 2'b00};
    assign misaligned_err = misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            rd_q         <= '0;
            funct3_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= accept && bad_req;
            if (accept) begin
                addr_q   <= ld_addr;
                rd_q     <= ld_rd;
                funct3_q <= ld_funct3;
            end
        end
    end

    // Write-port fields are captured with the response and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_rd     <= '0;
            rf_rd_din <= '0;
        end else if (state == S_WAIT && mem_rvalid) begin
            rf_rd     <= rd_q;
            rf_rd_din <= extend_load(mem_rdata, addr_q[1:0], funct3_q);
        end
    end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: vector table of full loads plus hand sequences
// for alignment errors, ignored handshakes, mid-operation reset and the optional timeout.
module tb_load_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_din;
    logic        rf_write_enable;
    logic        busy;
    logic        misaligned_err;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int req_cnt  = 0;

    load_writeback_unit #(.RF_ADDR_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_rd(rf_rd), .rf_rd_din(rf_rd_din), .rf_write_enable(rf_write_enable),
        .busy(busy), .misaligned_err(misaligned_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_write_enable === 1'b1) wr_cnt <= wr_cnt + 1;
        if (mem_req === 1'b1)         req_cnt <= req_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] exp_din;
        logic        exp_we;
    } vec_t;

    vec_t vecs[11];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
    } err_t;

    err_t errs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] addr, input logic [4:0] rd, input logic [2:0] f3);
        @(negedge clk);
        check("ld_ready_before_issue", {31'b0, ld_ready}, 32'd1);
        ld_valid  = 1'b1;
        ld_addr   = addr;
        ld_rd     = rd;
        ld_funct3 = f3;
        @(negedge clk);
        ld_valid  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int w0;
        w0 = wr_cnt;
        issue(v.addr, v.rd, v.f3);
        for (int i = 0; i < v.gnt_dly; i++) begin
            check("req_held_no_gnt", {31'b0, mem_req}, 32'd1);
            check("addr_held_no_gnt", mem_addr, v.addr & 32'hFFFF_FFFC);
            @(negedge clk);
        end
        check("mem_req_in_req", {31'b0, mem_req}, 32'd1);
        check("mem_addr_in_req", mem_addr, v.addr & 32'hFFFF_FFFC);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("mem_req_in_wait", {31'b0, mem_req}, 32'd0);
        check("busy_in_wait", {31'b0, busy}, 32'd1);
        for (int i = 0; i < v.rv_dly; i++) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hBAD0_BAD0;
        check("we_in_wb", {31'b0, rf_write_enable}, {31'b0, v.exp_we});
        if (v.exp_we) begin
            check("rf_rd_in_wb", {27'b0, rf_rd}, {27'b0, v.rd});
            check("rf_rd_din_in_wb", rf_rd_din, v.exp_din);
        end
        @(negedge clk);
        check("ld_ready_after_wb", {31'b0, ld_ready}, 32'd1);
        check("we_after_wb", {31'b0, rf_write_enable}, 32'd0);
        check("write_count", wr_cnt - w0, v.exp_we ? 32'd1 : 32'd0);
    endtask

    initial begin
        int w0;
        int r0;
        vecs[0]  = '{32'h0000_1000, 5'd5,  3'd2, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 1'b1};
        vecs[1]  = '{32'h0000_1000, 5'd1,  3'd0, 32'h8001_7F80, 0, 0, 32'hFFFF_FF80, 1'b1};
        vecs[2]  = '{32'h0000_1000, 5'd2,  3'd4, 32'h8001_7F80, 0, 0, 32'h0000_0080, 1'b1};
        vecs[3]  = '{32'h0000_1001, 5'd3,  3'd0, 32'h8001_7F80, 0, 1, 32'h0000_007F, 1'b1};
        vecs[4]  = '{32'h0000_1002, 5'd4,  3'd1, 32'h8001_7F80, 1, 0, 32'hFFFF_8001, 1'b1};
        vecs[5]  = '{32'h0000_1002, 5'd6,  3'd5, 32'h8001_7F80, 0, 0, 32'h0000_8001, 1'b1};
        vecs[6]  = '{32'h0000_2004, 5'd0,  3'd2, 32'h1234_5678, 5, 0, 32'h0,         1'b0};
        vecs[7]  = '{32'h0000_1003, 5'd31, 3'd4, 32'hA500_0000, 0, 2, 32'h0000_00A5, 1'b1};
        vecs[8]  = '{32'h0000_1002, 5'd8,  3'd0, 32'h0080_0000, 0, 0, 32'hFFFF_FF80, 1'b1};
        vecs[9]  = '{32'hFFFF_FFF0, 5'd9,  3'd5, 32'h0000_FFFF, 2, 0, 32'h0000_FFFF, 1'b1};
        vecs[10] = '{32'h0000_3000, 5'd10, 3'd1, 32'h7FFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1'b1};

        errs[0] = '{32'h0000_1002, 3'd2};
        errs[1] = '{32'h0000_1000, 3'd3};
        errs[2] = '{32'h0000_1000, 3'd6};
        errs[3] = '{32'h0000_1000, 3'd7};
        errs[4] = '{32'h0000_1001, 3'd1};
        errs[5] = '{32'h0000_1003, 3'd5};
        errs[6] = '{32'h0000_1001, 3'd2};

        reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_rd = '0; ld_funct3 = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_we", {31'b0, rf_write_enable}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_errs", {30'b0, misaligned_err, timeout_err}, 32'd0);
        check("rst_rf_rd", {27'b0, rf_rd}, 32'd0);
        check("rst_rf_rd_din", rf_rd_din, 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Alignment / funct3 errors
        for (int i = 0; i < 7; i++) begin
            w0 = wr_cnt;
            r0 = req_cnt;
            issue(errs[i].addr, 5'd12, errs[i].f3);
            check("err_pulse", {31'b0, misaligned_err}, 32'd1);
            check("err_ld_ready", {31'b0, ld_ready}, 32'd1);
            check("err_mem_req", {31'b0, mem_req}, 32'd0);
            @(negedge clk);
            check("err_pulse_end", {31'b0, misaligned_err}, 32'd0);
            check("err_no_req", req_cnt - r0, 32'd0);
            check("err_no_write", wr_cnt - w0, 32'd0);
        end

        // rvalid in REQ and in the gnt cycle must be ignored
        issue(32'h0000_2000, 5'd7, 3'd2);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_gnt = 1'b1; mem_rdata = 32'h2222_2222;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rdata = 32'h3333_3333;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("ignore_rv_we", {31'b0, rf_write_enable}, 32'd1);
        check("ignore_rv_din", rf_rd_din, 32'h3333_3333);
        @(negedge clk);
        check("ignore_rv_idle", {31'b0, ld_ready}, 32'd1);

        // Reset in REQ: request drops at the reset edge, write-port data cleared
        issue(32'h0000_4000, 5'd13, 3'd2);
        check("rstreq_req_before", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstreq_req_dropped", {31'b0, mem_req}, 32'd0);
        check("rstreq_ld_ready", {31'b0, ld_ready}, 32'd1);
        check("rstreq_din_cleared", rf_rd_din, 32'd0);

        // Reset in WAIT, then a stale response must not write
        w0 = wr_cnt;
        issue(32'h0000_5000, 5'd14, 3'd2);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rstwait_we", {31'b0, rf_write_enable}, 32'd0);
        check("rstwait_ld_ready", {31'b0, ld_ready}, 32'd1);
        @(negedge clk);
        check("rstwait_no_write", wr_cnt - w0, 32'd0);
        check("rstwait_din", rf_rd_din, 32'd0);

`ifdef LOAD_TIMEOUT_EN
        w0 = wr_cnt;
        issue(32'h0000_6000, 5'd15, 3'd2);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_busy_in_wait", {31'b0, busy}, 32'd1);
            check("to_no_early_pulse", {31'b0, timeout_err}, 32'd0);
            @(negedge clk);
        end
        check("to_pulse", {31'b0, timeout_err}, 32'd1);
        check("to_ld_ready", {31'b0, ld_ready}, 32'd1);
        @(negedge clk);
        check("to_pulse_end", {31'b0, timeout_err}, 32'd0);
        check("to_no_write", wr_cnt - w0, 32'd0);
`else
        w0 = wr_cnt;
        issue(32'h0000_6000, 5'd15, 3'd2);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("nto_busy_in_wait", {31'b0, busy}, 32'd1);
            check("nto_timeout_zero", {31'b0, timeout_err}, 32'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("nto_we", {31'b0, rf_write_enable}, 32'd1);
        check("nto_din", rf_rd_din, 32'h0BAD_CAFE);
        @(negedge clk);
        check("nto_one_write", wr_cnt - w0, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
